// File: rtl/ram_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl_if
//  Description : Bundle of the FIFO request/response signals and the
//                dual-port RAM command signals used by ram_fifo_ctrl.
//                The slave modport is the controller; the master modport is
//                the surrounding producer/consumer plus the external RAM.
//                Optional macro RAM_FIFO_ALMOST_EN adds almost_full/almost_empty.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ram_fifo_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;
    logic                  pop_valid;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_enb;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_enb;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
`ifdef RAM_FIFO_ALMOST_EN
    logic                  almost_full;
    logic                  almost_empty;
`endif

    modport slave (
`ifdef RAM_FIFO_ALMOST_EN
        output almost_full, almost_empty,
`endif
        input  push, push_data, pop, rd_data,
        output pop_data, pop_valid, full, empty, count, overflow, underflow,
        output wr_enb, wr_addr, wr_data, rd_enb, rd_addr
    );

    modport master (
`ifdef RAM_FIFO_ALMOST_EN
        input  almost_full, almost_empty,
`endif
        output push, push_data, pop, rd_data,
        input  pop_data, pop_valid, full, empty, count, overflow, underflow,
        input  wr_enb, wr_addr, wr_data, rd_enb, rd_addr
    );
endinterface
`default_nettype wire

// File: rtl/ram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ram_fifo_ctrl
//  Description : FIFO control stage in front of an external dual-port RAM
//                (registered write, registered read, 1-cycle read latency).
//                Turns push/pop requests into registered RAM write/read
//                commands, tracks pointers and occupancy, and returns read
//                data with a valid strobe two cycles after a pop accept.
//                Optional macro RAM_FIFO_ALMOST_EN adds almost_full/almost_empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_fifo_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
`ifdef RAM_FIFO_ALMOST_EN
    ,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 2,
    parameter int AE_THRESH  = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,     // synchronous, active-low
    ram_fifo_ctrl_if.slave    bus
);

    localparam logic [ADDR_WIDTH:0]   c_DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q,    rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,     count_d;
    logic                  wr_enb_q,    wr_enb_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q,   wr_data_d;
    logic                  rd_enb_q,    rd_enb_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q,   rd_addr_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;

    // Status flags come straight from the registered occupancy.
    assign w_full     = (count_q == c_DEPTH);
    assign w_empty    = (count_q == '0);
    assign w_push_acc = bus.push & ~w_full;
    assign w_pop_acc  = bus.pop  & ~w_empty;

    // Next-state: RAM commands, pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_enb_d    = w_push_acc;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_enb_d    = w_pop_acc;
        rd_addr_d   = rd_addr_q;
        // RAM answers the cycle after rd_enb is sampled, so valid trails rd_enb by one.
        pop_valid_d = rd_enb_q;
        overflow_d  = overflow_q  | (bus.push & w_full);
        underflow_d = underflow_q | (bus.pop  & w_empty);

        if (w_push_acc) begin
            wr_addr_d = wr_ptr_q;
            wr_data_d = bus.push_data;
            wr_ptr_d  = wr_ptr_q + c_PTR_ONE;   // natural wrap at depth
        end

        if (w_pop_acc) begin
            rd_addr_d = rd_ptr_q;
            rd_ptr_d  = rd_ptr_q + c_PTR_ONE;
        end

        case ({w_push_acc, w_pop_acc})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // State register; reset also drops any read that is still in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_enb_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_enb_q    <= 1'b0;
            rd_addr_q   <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_enb_q    <= wr_enb_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_enb_q    <= rd_enb_d;
            rd_addr_q   <= rd_addr_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.pop_data  = bus.rd_data;
    assign bus.pop_valid = pop_valid_q;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.wr_enb    = wr_enb_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.rd_enb    = rd_enb_q;
    assign bus.rd_addr   = rd_addr_q;

`ifdef RAM_FIFO_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] c_AF = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] c_AE = (ADDR_WIDTH+1)'(AE_THRESH);

    assign bus.almost_full  = (count_q >= c_AF);
    assign bus.almost_empty = (count_q <= c_AE);
`endif

endmodule
`default_nettype wire

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- FIFO control stage that sits directly upstream of the dual-port RAM and drives its write and read ports.
- Converts push/pop requests into registered wr_enb/wr_addr/wr_data and rd_enb/rd_addr commands.
- Tracks read/write pointers, occupancy and full/empty.
- Returns RAM read data to the consumer with a valid strobe.
- The RAM itself is external: one registered write, one registered read, 1-cycle read latency.

Parameters:
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, data word width.
- AF_THRESH, 2**ADDR_WIDTH-2, almost_full threshold (optional feature only).
- AE_THRESH, 2, almost_empty threshold (optional feature only).

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- push  input  1  write request.
- push_data  input  DATA_WIDTH  data to enqueue.
- pop  input  1  read request.
- pop_data  output  DATA_WIDTH  dequeued data; valid only while pop_valid=1.
- pop_valid  output  1  pop_data strobe.
- full  output  1  count == depth.
- empty  output  1  count == 0.
- count  output  ADDR_WIDTH+1  occupancy.
- overflow  output  1  sticky; push seen while full.
- underflow  output  1  sticky; pop seen while empty.
- wr_enb  output  1  RAM write enable.
- wr_addr  output  ADDR_WIDTH  RAM write address.
- wr_data  output  DATA_WIDTH  RAM write data.
- rd_enb  output  1  RAM read enable.
- rd_addr  output  ADDR_WIDTH  RAM read address.
- rd_data  input  DATA_WIDTH  RAM read data; valid the cycle after rd_enb is sampled.

Behaviour:
- Reset (rst=0 at posedge) clears:
  - wr_ptr, rd_ptr, count = 0.
  - wr_enb, rd_enb, pop_valid, overflow, underflow = 0.
  - wr_addr, rd_addr, wr_data = 0.
  - Result: empty=1, full=0.
- Reset mid-operation:
  - Any in-flight read is discarded; pop_valid stays 0 the cycle after reset even though RAM returns data.
  - RAM contents are not cleared.
- Push accept: push_acc = push & ~full.
  - Cycle N accept → cycle N+1: wr_enb=1, wr_addr=old wr_ptr, wr_data=push_data captured at N.
  - wr_ptr increments at end of N and wraps from depth-1 to 0.
- Pop accept: pop_acc = pop & ~empty.
  - Cycle N accept → cycle N+1: rd_enb=1, rd_addr=old rd_ptr.
  - Cycle N+2: pop_valid=1, pop_data=rd_data.
  - rd_ptr increments at end of N with wrap.
  - Pop-to-data latency is fixed at 2 cycles.
- wr_enb and rd_enb are 1-cycle pulses per accepted request; back-to-back accepts give continuous assertion with incrementing addresses.
- count update at end of each cycle:
  - +1 if push_acc only.
  - −1 if pop_acc only.
  - Unchanged if both or neither.
- full and empty are decoded combinationally from the registered count.
- Simultaneous push and pop:
  - Not full and not empty: both accepted.
  - When full: pop accepted, push rejected, overflow set.
  - When empty: push accepted, pop rejected, underflow set.
- No write-read hazard:
  - An entry pushed at N is written to RAM at end of N+1.
  - The earliest pop of that entry is accepted at N+1, so its read is issued at N+2.
- overflow/underflow stay set until reset.
- Rejected requests change no pointer, no count and no RAM command.

Optional Feature:
- Macro: RAM_FIFO_ALMOST_EN.
- Defined:
  - Adds output almost_full (1 bit) = count >= AF_THRESH.
  - Adds output almost_empty (1 bit) = count <= AE_THRESH.
  - Both combinational from registered count; reset values almost_full=0, almost_empty=1.
- Undefined:
  - Ports, thresholds and logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idle 5 cycles → empty=1, full=0, count=0, wr_enb=rd_enb=pop_valid=0.
- Push 0xA1, 0xB2, 0xC3 on consecutive cycles, then pop 3 → wr_addr 0,1,2 with matching wr_data; pop_valid on 3 consecutive cycles, 2 cycles after each pop accept; pop_data 0xA1, 0xB2, 0xC3; empty=1 at end.
- Push 16 words 0x00..0x0F, then push 0xFF → full=1, count=16, 0xFF not written, overflow=1; pop 16 → data 0x00..0x0F in order.
- Pop while empty → no rd_enb, underflow=1, count stays 0.
- Wrap: push/pop 40 words continuously with count held at 3 → addresses wrap 15→0, all data in order, count constant at 3.
- Assert reset one cycle after a pop accept → pop_valid never asserts for that pop, count=0, next push writes wr_addr=0.
- With RAM_FIFO_ALMOST_EN defined: push 14 words → almost_full=1 at count 14; pop 12 → almost_empty=1 at count 2.
